maj_popcount_accum: RTL

Downstream accumulation stage for the XNOR-majority array. Each beat carries P majority bits from P parallel XNOR-majority units. The block popcounts every beat and accumulates the counts across a group of beats terminated by `in_last`. It then compares the group total against a threshold and emits one binary activation per group over a valid/ready handshake.

---
 rtl/maj_pkg.sv | 45 ++++
 rtl/maj_popcount.sv | 30 +++
 rtl/maj_popcount_accum.sv | 115 +++++++++++
 3 files changed

// File: rtl/maj_pkg.sv
// Shared definitions for the XNOR-majority datapath stages.
//   pc_width(p)  : bits needed to hold a popcount of a p-bit vector (0..p)
//   ACC_W_DEFAULT: default accumulator / sum / threshold width
//   sat_add()    : unsigned add clipped to 2^w-1, also reporting the clip
//   out_state_t  : one-entry output register occupancy
package maj_pkg;

    localparam int ACC_W_DEFAULT = 12;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Result of a saturating add; sum never exceeds 2^w-1.
    typedef struct packed {
        logic        sat;
        logic [31:0] sum;
    } sat_sum_t;

    function automatic int pc_width(input int p);
        return $clog2(p + 1);
    endfunction

    // Operands are carried at 32 bits so one helper serves any width up to 31;
    // the extra carry bit keeps the unclipped sum exact for the overflow test.
    function automatic sat_sum_t sat_add(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input int unsigned w);
        sat_sum_t    res;
        logic [32:0] full_sum;
        logic [32:0] max_val;
        full_sum = {1'b0, a} + {1'b0, b};
        max_val  = (33'd1 << w) - 33'd1;
        if (full_sum > max_val) begin
            res.sat = 1'b1;
            res.sum = max_val[31:0];
        end else begin
            res.sat = 1'b0;
            res.sum = full_sum[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/maj_popcount.sv
// Combinational population count of a P-bit vector.
//   in_bits : P input bits
//   count   : number of set bits, pc_width(P) wide
module maj_popcount
    import maj_pkg::*;
#(
    parameter int P = 8
) (
    input  logic [P-1:0]           in_bits,
    output logic [pc_width(P)-1:0] count
);

    localparam int PC_W = pc_width(P);

    logic [PC_W-1:0] bit_ext [P];

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_ext
            assign bit_ext[gi] = PC_W'(in_bits[gi]);
        end
    endgenerate

    always_comb begin
        count = '0;
        for (int i = 0; i < P; i++) begin
            count = count + bit_ext[i];
        end
    end

endmodule

// File: rtl/maj_popcount_accum.sv
// Popcount-and-accumulate stage behind the XNOR-majority array.
// Each accepted beat adds popcount(in_m) to a saturating accumulator; the
// beat flagged in_last closes the group, and its total, threshold decision
// and saturation flag are registered into a one-entry output buffer.
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid/in_ready      : input beat handshake
//   in_m, in_last          : majority bits, end-of-group marker
//   thresh                 : activation threshold, used on the last beat
//   out_valid/out_ready    : result handshake
//   out_sum, out_act       : saturated group total, (out_sum >= thresh)
//   out_sat                : accumulator clipped somewhere in the group
module maj_popcount_accum
    import maj_pkg::*;
#(
    parameter int P     = 8,
    parameter int ACC_W = ACC_W_DEFAULT   // 2^ACC_W > P, at most 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P-1:0]     in_m,
    input  logic             in_last,
    input  logic [ACC_W-1:0] thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_act,
    output logic             out_sat
);

    localparam int PC_W = pc_width(P);

    logic [PC_W-1:0]  pc;
    sat_sum_t         sum_res;
    logic [ACC_W-1:0] nxt;
    logic             beat_sat;
    logic             act_next;
    logic             accept;
    logic             last_accept;
    logic             drain;

    logic [ACC_W-1:0] acc_reg;
    logic             sat_acc_reg;
    logic [ACC_W-1:0] out_sum_reg;
    logic             out_act_reg;
    logic             out_sat_reg;
    out_state_t       state_reg;
    out_state_t       state_next;

    maj_popcount #(.P(P)) u_popcount (
        .in_bits (in_m),
        .count   (pc)
    );

    // The clipped sum fits in ACC_W bits, so its upper bits are zero and the
    // 32-bit compare equals the ACC_W-bit unsigned compare.
    assign sum_res  = sat_add(32'(acc_reg), 32'(pc), ACC_W);
    assign nxt      = sum_res.sum[ACC_W-1:0];
    assign beat_sat = sum_res.sat;
    assign act_next = (sum_res.sum >= 32'(thresh));

    // A drained slot can be refilled in the same cycle, so a full buffer
    // only stalls the input while the consumer is not taking it.
    assign in_ready    = (state_reg == ST_EMPTY) || out_ready;
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && in_last;
    assign drain       = (state_reg == ST_FULL) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (last_accept)           state_next = ST_FULL;
            ST_FULL:  if (drain && !last_accept) state_next = ST_EMPTY;
            default:                             state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg     <= '0;
            sat_acc_reg <= 1'b0;
            out_sum_reg <= '0;
            out_act_reg <= 1'b0;
            out_sat_reg <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                out_sum_reg <= nxt;
                out_act_reg <= act_next;
                out_sat_reg <= sat_acc_reg | beat_sat;
                acc_reg     <= '0;
                sat_acc_reg <= 1'b0;
            end else begin
                acc_reg <= nxt;
                if (beat_sat) begin
                    sat_acc_reg <= 1'b1;
                end
            end
        end
    end

    assign out_valid = (state_reg == ST_FULL);
    assign out_sum   = out_sum_reg;
    assign out_act   = out_act_reg;
    assign out_sat   = out_sat_reg;

endmodule
